// File: rtl/load_unit.sv
// load_unit: memory-stage load unit (LB/LH/LW/LD/LBU/LHU/LWU) for XLEN 32 or 64.
// Define LOAD_MISALIGN_EN to split word-crossing loads into two reads; otherwise they fault.
module load_unit #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [XLEN-1:0]  req_addr,
  input  logic [2:0]       req_funct3,
  input  logic [TAG_W-1:0] req_tag,
  output logic             mem_req_valid,
  input  logic             mem_req_ready,
  output logic [XLEN-1:0]  mem_addr,
  input  logic             mem_rsp_valid,
  input  logic [XLEN-1:0]  mem_rdata,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [XLEN-1:0]  rsp_data,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_fault,
  output logic             busy
);
  localparam int NB = XLEN / 8;
  localparam int OB = $clog2(NB);
`ifdef LOAD_MISALIGN_EN
  localparam bit MIS = 1'b1;
`else
  localparam bit MIS = 1'b0;
`endif
  typedef enum logic [2:0] {IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP} state_t;
  state_t r_state, w_next;
  logic [XLEN-1:0]  r_addr, r_lo, r_data, w_base, w_ext;
  logic [2:0]       r_f3;
  logic [TAG_W-1:0] r_tag;
  logic             r_fault, w_fault_in, w_cross;
  function automatic logic crosses(input logic [OB-1:0] off, input logic [1:0] sz);
    return (5'(off) + (5'd1 << sz)) > 5'(NB);
  endfunction
  function automatic logic illegal(input logic [2:0] f3);
    return f3 == 3'b111 || (XLEN == 32 && (f3 == 3'b011 || f3 == 3'b110));
  endfunction
  // Left-justify the datum, then shift back down arithmetically or logically to extend it.
  function automatic logic [XLEN-1:0] extract(input logic [2*XLEN-1:0] v, input logic [OB-1:0] off,
                                              input logic [2:0] f3);
    logic [2*XLEN-1:0] t;
    logic [XLEN-1:0]   s;
    logic [6:0]        sh;
    t  = v >> {off, 3'b000};
    s  = t[XLEN-1:0];
    sh = 7'(XLEN) - (7'd8 << f3[1:0]);
    s  = s << sh;
    if (f3[2]) s = s >> sh;
    else s = $signed(s) >>> sh;
    return s;
  endfunction
  assign w_base     = {r_addr[XLEN-1:OB], {OB{1'b0}}};
  assign w_fault_in = illegal(req_funct3) || (!MIS && crosses(req_addr[OB-1:0], req_funct3[1:0]));
  assign w_cross    = MIS && crosses(r_addr[OB-1:0], r_f3[1:0]);
  assign w_ext      = extract(r_state == WAIT1 ? {mem_rdata, r_lo} : {{XLEN{1'b0}}, mem_rdata},
                              r_addr[OB-1:0], r_f3);
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (req_valid) w_next = w_fault_in ? RESP : REQ0;
      REQ0:    if (mem_req_ready) w_next = WAIT0;
      WAIT0:   if (mem_rsp_valid) w_next = w_cross ? REQ1 : RESP;
      REQ1:    if (mem_req_ready) w_next = WAIT1;
      WAIT1:   if (mem_rsp_valid) w_next = RESP;
      RESP:    if (rsp_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end
  always_comb begin
    req_ready     = r_state == IDLE;
    busy          = r_state != IDLE;
    mem_req_valid = r_state == REQ0 || r_state == REQ1;
    mem_addr      = r_state == REQ0 ? w_base : r_state == REQ1 ? w_base + XLEN'(NB) : '0;
    rsp_valid     = r_state == RESP;
    rsp_data      = r_data;
    rsp_tag       = r_tag;
    rsp_fault     = r_fault;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr  <= '0;
      r_f3    <= '0;
      r_tag   <= '0;
      r_fault <= 1'b0;
      r_lo    <= '0;
      r_data  <= '0;
    end else begin
      if (r_state == IDLE && req_valid) begin
        r_addr  <= req_addr;
        r_f3    <= req_funct3;
        r_tag   <= req_tag;
        r_fault <= w_fault_in;
        r_data  <= '0;
      end
      if (r_state == WAIT0 && mem_rsp_valid) r_lo <= mem_rdata;
      if (mem_rsp_valid && ((r_state == WAIT0 && !w_cross) || r_state == WAIT1)) r_data <= w_ext;
    end
  end
endmodule
